// File: rtl/tmrcnt_pkg.sv
// Shared constants for the TmrCnt timer channels:
// clock-select encoding, counter width and flag bit indices.
package tmrcnt_pkg;

    localparam int TCNT_W = 8;

    localparam logic [2:0] CS_STOP    = 3'd0;
    localparam logic [2:0] CS_CLK     = 3'd1;
    localparam logic [2:0] CS_DIV8    = 3'd2;
    localparam logic [2:0] CS_DIV64   = 3'd3;
    localparam logic [2:0] CS_DIV256  = 3'd4;
    localparam logic [2:0] CS_DIV1024 = 3'd5;
    localparam logic [2:0] CS_TFALL   = 3'd6;
    localparam logic [2:0] CS_TRISE   = 3'd7;

    localparam int FLG_TOV = 0;
    localparam int FLG_OCF = 1;

endpackage

// File: rtl/tmr_pin_sync.sv
// External timer pin synchronizer with single-cycle rise/fall pulses.
// Ports: clk, reset (sync, active-high), pin (async), rise, fall.
module tmr_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;

    // The delayed copy runs regardless of clock select, so switching
    // between edge sources never fabricates an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            dly  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            dly  <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~dly;
    assign fall = ~sync[SYNC_STAGES-1] & dly;

endmodule

// File: rtl/tmr8_cs_counter.sv
// 8-bit timer/counter with clock select, overflow and compare-A flags.
// Ports: clk, reset (sync, active-high), cs, clk8en..clk1024en, t_pin,
//   tcnt_we, tcnt_wdata, ocr, flag_clr, ctc (TMR_CTC_EN only),
//   tcnt, tov, ocf, tick.
// Macro TMR_CTC_EN adds clear-timer-on-compare mode.
module tmr8_cs_counter
    import tmrcnt_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        cs,
    input  logic              clk8en,
    input  logic              clk64en,
    input  logic              clk256en,
    input  logic              clk1024en,
    input  logic              t_pin,
    input  logic              tcnt_we,
    input  logic [TCNT_W-1:0] tcnt_wdata,
    input  logic [TCNT_W-1:0] ocr,
    input  logic [1:0]        flag_clr,
`ifdef TMR_CTC_EN
    input  logic              ctc,
`endif
    output logic [TCNT_W-1:0] tcnt,
    output logic              tov,
    output logic              ocf,
    output logic              tick
);

    logic pin_rise;
    logic pin_fall;
    logic cnt_en;
    logic inc;
    logic ovf;
    logic match;
    logic ctc_clr;

    tmr_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clk  (clk),
        .reset(reset),
        .pin  (t_pin),
        .rise (pin_rise),
        .fall (pin_fall)
    );

    always_comb begin
        cnt_en = 1'b0;
        unique case (cs)
            CS_STOP:    cnt_en = 1'b0;
            CS_CLK:     cnt_en = 1'b1;
            CS_DIV8:    cnt_en = clk8en;
            CS_DIV64:   cnt_en = clk64en;
            CS_DIV256:  cnt_en = clk256en;
            CS_DIV1024: cnt_en = clk1024en;
            CS_TFALL:   cnt_en = pin_fall;
            CS_TRISE:   cnt_en = pin_rise;
        endcase
    end

    // A CPU write masks the count event entirely.
    assign inc   = cnt_en & ~tcnt_we;
    assign ovf   = inc & (tcnt == {TCNT_W{1'b1}});
    assign match = inc & (tcnt == ocr);

`ifdef TMR_CTC_EN
    assign ctc_clr = match & ctc;
`else
    assign ctc_clr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
            tov  <= 1'b0;
            ocf  <= 1'b0;
            tick <= 1'b0;
        end else begin
            if (tcnt_we)
                tcnt <= tcnt_wdata;
            else if (ctc_clr)
                tcnt <= '0;
            else if (cnt_en)
                tcnt <= tcnt + 1'b1;
            // Set beats clear in the same cycle.
            tov  <= ovf | (tov & ~flag_clr[FLG_TOV]);
            ocf  <= match | (ocf & ~flag_clr[FLG_OCF]);
            tick <= inc;
        end
    end

endmodule

// File: tb/tb_tmr8_cs_counter.sv
// Self-checking bench for tmr8_cs_counter: reference model plus
// directed scenarios with literal expectations.
module tb_tmr8_cs_counter;

    localparam int SS = 2;
`ifdef TMR_CTC_EN
    localparam bit HAS_CTC = 1'b1;
`else
    localparam bit HAS_CTC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] cs;
    logic       t_pin;
    logic       tcnt_we;
    logic [7:0] tcnt_wdata;
    logic [7:0] ocr;
    logic [1:0] flag_clr;
    logic       ctc;
    logic [7:0] tcnt;
    logic       tov;
    logic       ocf;
    logic       tick;

    logic [9:0] psc;
    logic       clk8en;
    logic       clk64en;
    logic       clk256en;
    logic       clk1024en;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    // Free-running prescaler feeding the strobes
    always @(posedge clk) begin
        if (reset) psc <= '0;
        else       psc <= psc + 10'd1;
    end
    assign clk8en    = &psc[2:0];
    assign clk64en   = &psc[5:0];
    assign clk256en  = &psc[7:0];
    assign clk1024en = &psc[9:0];

    tmr8_cs_counter #(.SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .clk8en    (clk8en),
        .clk64en   (clk64en),
        .clk256en  (clk256en),
        .clk1024en (clk1024en),
        .t_pin     (t_pin),
        .tcnt_we   (tcnt_we),
        .tcnt_wdata(tcnt_wdata),
        .ocr       (ocr),
        .flag_clr  (flag_clr),
`ifdef TMR_CTC_EN
        .ctc       (ctc),
`endif
        .tcnt      (tcnt),
        .tov       (tov),
        .ocf       (ocf),
        .tick      (tick)
    );

    // Reference model. ph[k] is the pin level sampled k+1 edges ago;
    // a pin edge becomes a count event SS edges after first sampling.
    int   m_cnt  = 0;
    bit   m_tov  = 0;
    bit   m_ocf  = 0;
    bit   m_tick = 0;
    bit   ph [0:3] = '{0, 0, 0, 0};

    function automatic bit src_en(input int sel);
        bit r, f;
        r = ph[SS-1] && !ph[SS];
        f = !ph[SS-1] && ph[SS];
        case (sel)
            0: return 1'b0;
            1: return 1'b1;
            2: return clk8en;
            3: return clk64en;
            4: return clk256en;
            5: return clk1024en;
            6: return f;
            default: return r;
        endcase
    endfunction

    always @(posedge clk) begin
        bit ev;
        ev = src_en(int'(cs)) && !tcnt_we;
        if (reset) begin
            m_cnt  <= 0;
            m_tov  <= 0;
            m_ocf  <= 0;
            m_tick <= 0;
            ph     <= '{0, 0, 0, 0};
        end else begin
            if (tcnt_we)
                m_cnt <= int'(tcnt_wdata);
            else if (ev && HAS_CTC && ctc && m_cnt == int'(ocr))
                m_cnt <= 0;
            else if (ev)
                m_cnt <= (m_cnt + 1) % 256;
            m_tov  <= (ev && m_cnt == 255) || (m_tov && !flag_clr[0]);
            m_ocf  <= (ev && m_cnt == int'(ocr))
                      || (m_ocf && !flag_clr[1]);
            m_tick <= ev;
            ph     <= '{t_pin, ph[0], ph[1], ph[2]};
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checks = checks + 4;
            if (tcnt !== 8'(m_cnt)) begin
                errors = errors + 1;
                $display("FAIL model_tcnt got %h exp %h",
                         tcnt, 8'(m_cnt));
            end
            if (tov !== m_tov) begin
                errors = errors + 1;
                $display("FAIL model_tov got %b exp %b", tov, m_tov);
            end
            if (ocf !== m_ocf) begin
                errors = errors + 1;
                $display("FAIL model_ocf got %b exp %b", ocf, m_ocf);
            end
            if (tick !== m_tick) begin
                errors = errors + 1;
                $display("FAIL model_tick got %b exp %b", tick, m_tick);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        cs         = 3'd1;
        t_pin      = 1'b0;
        tcnt_we    = 1'b0;
        tcnt_wdata = 8'h00;
        ocr        = 8'h10;
        flag_clr   = 2'b00;
        ctc        = 1'b0;
        step(1);
        armed = 1'b1;
        step(1);
        chk("rst_tcnt", tcnt, 8'h00);
        chk("rst_tov", {7'd0, tov}, 8'h00);
        chk("rst_ocf", {7'd0, ocf}, 8'h00);
        chk("rst_tick", {7'd0, tick}, 8'h00);

        // cs=1 free run
        reset = 1'b0;
        step(16);
        chk("clk_pre_cmp", tcnt, 8'h10);
        chk("clk_ocf0", {7'd0, ocf}, 8'h00);
        step(1);
        chk("clk_cmp_cnt", tcnt, 8'h11);
        chk("clk_ocf1", {7'd0, ocf}, 8'h01);
        step(238);
        chk("clk_ff", tcnt, 8'hFF);
        chk("clk_tov0", {7'd0, tov}, 8'h00);
        step(1);
        chk("clk_wrap", tcnt, 8'h00);
        chk("clk_tov1", {7'd0, tov}, 8'h01);
        step(1);
        chk("clk_257", tcnt, 8'h01);

        // cs=3 with the prescaler
        cs  = 3'd3;
        ocr = 8'hFF;
        do_reset();
        step(63);
        chk("div64_63", tcnt, 8'h00);
        step(1);
        chk("div64_64", tcnt, 8'h01);
        step(192);
        chk("div64_256", tcnt, 8'h04);

        // external pin edges
        cs = 3'd7;
        do_reset();
        t_pin = 1'b1;
        step(2);
        chk("pin_lat2", tcnt, 8'h00);
        step(1);
        chk("pin_lat3", tcnt, 8'h01);
        step(7);
        t_pin = 1'b0;
        step(10);
        chk("pin_fall_ign", tcnt, 8'h01);
        t_pin = 1'b1;
        step(10);
        chk("pin_rise2", tcnt, 8'h02);
        cs = 3'd6;
        step(10);
        chk("pin_switch", tcnt, 8'h02);
        t_pin = 1'b0;
        step(2);
        chk("pin_f_lat2", tcnt, 8'h02);
        step(1);
        chk("pin_f_lat3", tcnt, 8'h03);
        step(7);
        t_pin = 1'b1;
        step(10);
        chk("pin_rise_ign", tcnt, 8'h03);

        // write collides with count at compare
        cs  = 3'd1;
        ocr = 8'h20;
        do_reset();
        step(32);
        chk("wr_pre", tcnt, 8'h20);
        tcnt_we    = 1'b1;
        tcnt_wdata = 8'h7F;
        step(1);
        tcnt_we = 1'b0;
        chk("wr_val", tcnt, 8'h7F);
        chk("wr_ocf0", {7'd0, ocf}, 8'h00);
        chk("wr_tick0", {7'd0, tick}, 8'h00);
        step(1);
        chk("wr_next", tcnt, 8'h80);
        chk("wr_tick1", {7'd0, tick}, 8'h01);

        // clear racing an overflow set
        tcnt_we    = 1'b1;
        tcnt_wdata = 8'hF0;
        ocr        = 8'hF0;
        step(1);
        tcnt_we = 1'b0;
        step(1);
        chk("fc_ocf_set", {7'd0, ocf}, 8'h01);
        step(14);
        chk("fc_ff", tcnt, 8'hFF);
        flag_clr = 2'b11;
        step(1);
        chk("fc_tov_wins", {7'd0, tov}, 8'h01);
        chk("fc_ocf_clr", {7'd0, ocf}, 8'h00);
        flag_clr = 2'b01;
        step(1);
        flag_clr = 2'b00;
        chk("fc_tov_clr", {7'd0, tov}, 8'h00);
        cs = 3'd0;
        step(5);
        chk("stop_hold", tcnt, 8'h01);

`ifdef TMR_CTC_EN
        cs  = 3'd1;
        ocr = 8'h05;
        ctc = 1'b1;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            step(1);
            flag_clr = 2'b00;
            chk("ctc_seq", tcnt, 8'(k % 6));
            if (k % 6 == 0) begin
                chk("ctc_ocf", {7'd0, ocf}, 8'h01);
                flag_clr = 2'b10;
            end
        end
        chk("ctc_tov0", {7'd0, tov}, 8'h00);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("ctc_rst_cnt", tcnt, 8'h00);
        chk("ctc_rst_ocf", {7'd0, ocf}, 8'h00);
        chk("ctc_rst_tick", {7'd0, tick}, 8'h00);
        ctc = 1'b0;
`endif

        step(2);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
